hoaaned_arb_ctrl: RTL
=====================

Name: hoaaned_arb_ctrl

Overview:
Sequencing controller and 2-way arbiter around one shared hybrid approximate adder (HOAANED style). Lower LSB_W bits use an OR approximation; upper bits use an exact add with no carry-in. The block detects when the approximation is wrong. On an error, and if correction is enabled, it spends one extra cycle producing the exact sum. It sits between two operand producers and one result consumer, and also keeps a saturating error counter for accuracy monitoring.

Parameters:
WIDTH, 8, operand width in bits.
LSB_W, 4, number of approximated low bits (1..WIDTH-1).
CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  synchronous active-low reset.
req0_valid  input  1  requester 0 has operands.
req0_ready  output  1  requester 0 operands accepted this cycle.
req0_a  input  WIDTH  requester 0 operand A.
req0_b  input  WIDTH  requester 0 operand B.
req1_valid  input  1  requester 1 has operands.
req1_ready  output  1  requester 1 operands accepted this cycle.
req1_a  input  WIDTH  requester 1 operand A.
req1_b  input  WIDTH  requester 1 operand B.
cfg_correct  input  1  enables the exact-correction pass; sampled at accept.
cnt_clr  input  1  synchronous clear of err_count.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts the result.
res_sum  output  WIDTH+1  result sum.
res_id  output  1  requester index of the result.
res_err  output  1  approximation error detected for this transaction.
res_corrected  output  1  res_sum is the exact sum.
err_count  output  CNT_W  saturating count of detected errors.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - res_valid, res_sum, res_id, res_err, res_corrected and err_count all go to 0.
  - last_grant goes to 1, so requester 0 wins the first tie.
  - Any in-flight transaction is discarded.
  - reqX_ready is 0 while rst_n is low.
- States: IDLE, APPROX, CORRECT, HOLD.
- IDLE: reqX_ready is combinational and asserted only in IDLE.
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant (round robin).
  - On the grant (accept cycle T), latch a, b, id and cfg_correct into internal registers, update last_grant, and go to APPROX.
- APPROX (T+1):
  - approx = {a[W-1:L]+b[W-1:L] (W-L+1 bits, no carry-in), a[L-1:0]|b[L-1:0]}.
  - err = |(a[L-1:0] & b[L-1:0]). A nonzero AND is exactly the condition under which the OR approximation differs from the exact sum.
  - If err and latched cfg_correct: go to CORRECT.
  - Otherwise: register res_sum=approx, res_err=err, res_corrected=~err, set res_valid, and go to HOLD.
- CORRECT (T+2):
  - res_sum = a+b (WIDTH+1 bits, exact), res_err=1, res_corrected=1.
  - Set res_valid and go to HOLD.
- Latency: accept to res_valid is 2 cycles with no correction pass, 3 cycles with one.
- HOLD:
  - res_* stay stable while res_valid=1 and res_ready=0.
  - On res_valid & res_ready, clear res_valid and go to IDLE.
  - The next accept can happen in the cycle after the handshake; no back-to-back accept in the handshake cycle.
- err_count:
  - Increments by 1 in the cycle err is evaluated in APPROX with err=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment; clear wins on a simultaneous event.
  - Unaffected by res_ready stalls.
- Operand changes on reqX_a/b after the accept cycle have no effect. A requester that is not granted must keep valid high; its data is not latched.

Test Plan:
1. Reset, then req0 a=0x35 b=0x42, cfg_correct=1 -> req0_ready at T; at T+2 res_sum=0x077, res_err=0, res_corrected=1, res_id=0; err_count stays 0.
2. req1 a=0x0F b=0x01, cfg_correct=1 -> res_valid at T+3, res_sum=0x010, res_err=1, res_corrected=1, res_id=1; err_count=1.
3. Same operands with cfg_correct=0 -> res_valid at T+2, res_sum=0x00F, res_err=1, res_corrected=0. Also a=0xFF b=0xFF with cfg_correct=0 -> res_sum=0x1EF.
4. Both requesters valid continuously, res_ready=1 -> grants after reset alternate 0,1,0,1; each result's res_id matches its grant order.
5. Hold res_ready=0 for 5 cycles after res_valid -> res_* stable; reqX_ready stays 0. Release -> handshake, then a new accept on the next cycle.
6. With CNT_W=2, force 4 errors -> err_count goes 1,2,3,3. Assert cnt_clr together with an error -> err_count=0. Assert rst_n=0 during CORRECT -> next cycle res_valid=0, state IDLE, no stale result later.

Source files
------------

// File: rtl/hoaaned_arb_ctrl.sv
// Two-way round-robin front end for a shared hybrid approximate adder.
// OR-approximates the low bits, detects the error, optionally re-adds exactly.
module hoaaned_arb_ctrl #(
   parameter int WIDTH = 8,
   parameter int LSB_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             cfg_correct,
   input  logic             cnt_clr,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH:0]   res_sum,
   output logic             res_id,
   output logic             res_err,
   output logic             res_corrected,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      APPROX  = 2'd1,
      CORRECT = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0]     a_q, b_q;
   logic                 id_q, corr_q;
   logic                 last_grant;
   logic                 gnt0, gnt1, accept;
   logic [WIDTH-LSB_W:0] hi_sum;
   logic [LSB_W-1:0]     lo_or;
   logic                 err;
   logic [WIDTH:0]       approx, exact;
   logic                 cnt_max;

   // Ties go to the requester that did not win last time.
   assign gnt0 = req0_valid & (~req1_valid | last_grant);
   assign gnt1 = req1_valid & (~req0_valid | ~last_grant);

   assign hi_sum  = {1'b0, a_q[WIDTH-1:LSB_W]} + {1'b0, b_q[WIDTH-1:LSB_W]};
   assign lo_or   = a_q[LSB_W-1:0] | b_q[LSB_W-1:0];
   assign err     = |(a_q[LSB_W-1:0] & b_q[LSB_W-1:0]);
   assign approx  = {hi_sum, lo_or};
   assign exact   = {1'b0, a_q} + {1'b0, b_q};
   assign cnt_max = &err_count;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (req0_valid | req1_valid) state_nx = APPROX;
         APPROX:  state_nx = (err & corr_q) ? CORRECT : HOLD;
         CORRECT: state_nx = HOLD;
         HOLD:    if (res_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      req0_ready = rst_n & (state == IDLE) & gnt0;
      req1_ready = rst_n & (state == IDLE) & gnt1;
      accept     = req0_ready | req1_ready;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q           <= '0;
         b_q           <= '0;
         id_q          <= 1'b0;
         corr_q        <= 1'b0;
         last_grant    <= 1'b1;
         res_valid     <= 1'b0;
         res_sum       <= '0;
         res_id        <= 1'b0;
         res_err       <= 1'b0;
         res_corrected <= 1'b0;
      end else begin
         if (accept) begin
            a_q        <= gnt1 ? req1_a : req0_a;
            b_q        <= gnt1 ? req1_b : req0_b;
            id_q       <= gnt1;
            corr_q     <= cfg_correct;
            last_grant <= gnt1;
         end
         unique case (state)
            APPROX: begin
               if (!(err & corr_q)) begin
                  res_sum       <= approx;
                  res_err       <= err;
                  res_corrected <= ~err;
                  res_id        <= id_q;
                  res_valid     <= 1'b1;
               end
            end
            CORRECT: begin
               res_sum       <= exact;
               res_err       <= 1'b1;
               res_corrected <= 1'b1;
               res_id        <= id_q;
               res_valid     <= 1'b1;
            end
            HOLD: if (res_ready) res_valid <= 1'b0;
            default: ;
         endcase
      end
   end

   // Clear beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (!rst_n || cnt_clr)
         err_count <= '0;
      else if (state == APPROX && err && !cnt_max)
         err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
   end

endmodule
